aes_stream_io: RTL
==================

# aes_stream_io

Word-serial front/back end for the combinational AES-128 encryption core. Accepts a plaintext block as four 32-bit words on a valid/ready stream and holds it, with a registered cipher key, stable on the core inputs. Waits a programmable number of cycles for the core's combinational path to settle, captures the 128-bit ciphertext, and returns it as four 32-bit words on an output valid/ready stream. Sits directly upstream of the core's `in`/`Key` ports and directly downstream of its `out` port.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles the core output is allowed to settle before capture; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  128  cipher key, sampled on a key_load accept
- key_load  in  1  key load request
- s_data  in  32  plaintext word
- s_valid  in  1  plaintext word valid
- s_ready  out  1  packer can accept a word
- m_data  out  32  ciphertext word
- m_valid  out  1  ciphertext word valid
- m_ready  in  1  sink accepts ciphertext word
- m_last  out  1  marks the 4th ciphertext word of a block
- core_in  out  128  plaintext to core
- core_key  out  128  key to core
- core_out  in  128  ciphertext from core
- busy  out  1  high in SETTLE or DRAIN

## Operation
- Clock and reset are decided: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Word order is FIPS-197 byte order: word 0 is bits [127:96], word 3 is bits [31:0], for both input and output.
- FSM states:
  - FILL: s_ready=1. Each s_valid&s_ready writes s_data into the slot given by a 2-bit word counter, which then increments. The accept of word 3 moves to SETTLE, wraps the counter to 0 and loads the settle counter with SETTLE_CYCLES.
  - SETTLE: s_ready=0. core_in and core_key are held stable. The settle counter decrements each cycle. In the cycle it reads 1, core_out is registered into the result register, the output index is cleared, and the state moves to DRAIN.
  - DRAIN: m_valid=1. m_data = result word[index]. m_last=1 when index==3. Each m_valid&m_ready increments the index. The handshake with index==3 returns the FSM to FILL.
- core_in is the plaintext register. Words written during FILL appear on core_in in the next cycle; only the SETTLE capture is meaningful.
- Key handling:
  - key_load is honoured only in FILL with the word counter at 0. key_in is registered into core_key on that edge.
  - If key_load and the accept of word 0 happen in the same cycle, both take effect, and the new key applies to that block.
  - key_load in any other state or count is ignored, with no side effects.
- m_data, m_valid and m_last are stable while m_valid=1 and m_ready=0.
- s_valid in SETTLE or DRAIN is ignored; data is not consumed.

## Timing
- Reset values:
  - FSM=FILL, word counter=0, index=0, settle counter=0.
  - s_ready=1 once rst_n is high. s_ready is 0 while rst_n is low.
  - m_valid=0, m_last=0, m_data=0, busy=0, core_in=0, core_key=0.
- Let T be the edge accepting word 3. Then:
  - busy=1 from T+1.
  - Capture happens at edge T+SETTLE_CYCLES.
  - m_valid=1 from T+SETTLE_CYCLES onward.
- With no backpressure, a block occupies 4 + SETTLE_CYCLES + 4 cycles, and s_ready returns 1 the cycle after the m_last handshake.
- Reset mid-operation asynchronously returns everything to the reset values. A partially filled or partially drained block is discarded.
- Input and output never overlap. This is a single-block buffer; no output is lost under arbitrary m_ready stalls.

## Test plan
- FIPS-197 C.1: key_load with key 000102030405060708090a0b0c0d0e0f, then words 00112233, 44556677, 8899aabb, ccddeeff -> output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with m_last on the 4th and m_valid first high exactly SETTLE_CYCLES cycles after the word-3 accept.
- Backpressure: m_ready low for 5 cycles on each word -> m_data and m_last held, the same 4 words delivered in order, and s_ready=0 until the final handshake.
- Key rules:
  - key_load asserted mid-fill (count=2) -> ignored; ciphertext matches the old key.
  - key_load together with the word-0 accept -> ciphertext matches the new key.
- s_valid held high during SETTLE and DRAIN -> no word consumed. The next block starts cleanly, and back-to-back blocks produce correct ciphertexts.
- Reset asserted after word 2 of a fill, and again during DRAIN index 1:
  - All outputs go to reset values immediately.
  - The next full block encrypts correctly.
  - No stale words are emitted.
- Parameter sweep SETTLE_CYCLES=1 and 15 -> latency matches the Timing section; results are identical.

Source files
------------

// File: rtl/aes_stream_io.sv
// aes_stream_io
// Word-serial front/back end for a combinational AES-128 encryption core.
// Collects four 32-bit plaintext words, holds them with the registered key
// on the core inputs, waits SETTLE_CYCLES for the core to settle, captures
// the ciphertext and streams it back out as four 32-bit words.
// Word 0 is always bits [127:96] (FIPS-197 byte order).

module aes_stream_io #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    // Select 32-bit word i of a 128-bit block, word 0 being the MSBs.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [1:0]     wcnt_r;
    logic [3:0]     settle_r;
    logic [1:0]     idx_r;
    logic [127:0]   pt_r;
    logic [127:0]   key_r;
    logic [127:0]   res_r;
    logic [31:0]    m_data_r;
    logic           m_valid_r;
    logic           m_last_r;
    logic           busy_r;

    logic           in_acc_s;
    logic           last_in_s;
    logic           key_acc_s;
    logic           capture_s;
    logic           out_acc_s;
    logic           out_done_s;

    // Handshake and event decode from the current state.
    always_comb begin
        in_acc_s   = 1'b0;
        last_in_s  = 1'b0;
        key_acc_s  = 1'b0;
        capture_s  = 1'b0;
        out_acc_s  = 1'b0;
        out_done_s = 1'b0;
        if (state_r == ST_FILL) begin
            in_acc_s  = s_valid;
            last_in_s = s_valid && (wcnt_r == 2'd3);
            key_acc_s = key_load && (wcnt_r == 2'd0);
        end else if (state_r == ST_SETTLE) begin
            // A zero count can only arise from an illegal parameter; capture
            // anyway so the block cannot lock up.
            capture_s = (settle_r <= 4'd1);
        end else begin
            out_acc_s  = m_valid_r && m_ready;
            out_done_s = m_valid_r && m_ready && (idx_r == 2'd3);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (last_in_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_SETTLE: begin
                if (capture_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_DRAIN: begin
                if (out_done_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Input side: word counter, plaintext slots, key register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= 2'd0;
            pt_r   <= 128'd0;
            key_r  <= 128'd0;
        end else begin
            if (key_acc_s) begin
                key_r <= key_in;
            end
            if (in_acc_s) begin
                wcnt_r <= wcnt_r + 2'd1;
                case (wcnt_r)
                    2'd0:    pt_r[127:96] <= s_data;
                    2'd1:    pt_r[95:64]  <= s_data;
                    2'd2:    pt_r[63:32]  <= s_data;
                    2'd3:    pt_r[31:0]   <= s_data;
                    default: pt_r         <= pt_r;
                endcase
            end
        end
    end

    // Settle countdown while the core path resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 4'd0;
        end else if (last_in_s) begin
            settle_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (settle_r != 4'd0)) begin
            settle_r <= settle_r - 4'd1;
        end
    end

    // Output side: result capture, word index and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r     <= 128'd0;
            idx_r     <= 2'd0;
            m_data_r  <= 32'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (capture_s) begin
            res_r     <= core_out;
            idx_r     <= 2'd0;
            m_data_r  <= word_sel(core_out, 2'd0);
            m_valid_r <= 1'b1;
            m_last_r  <= 1'b0;
        end else if (out_done_s) begin
            idx_r     <= 2'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (out_acc_s) begin
            idx_r    <= idx_r + 2'd1;
            m_data_r <= word_sel(res_r, idx_r + 2'd1);
            m_last_r <= ((idx_r + 2'd1) == 2'd3);
        end
    end

    // Busy flag tracks the non-FILL states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_FILL);
        end
    end

    // s_ready is gated by rst_n so it is low for the whole reset interval.
    assign s_ready  = rst_n && (state_r == ST_FILL);
    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign m_last   = m_last_r;
    assign core_in  = pt_r;
    assign core_key = key_r;
    assign busy     = busy_r;

endmodule
